// File: rtl/avmm_region_bridge_if.sv
// Avalon-MM style request/response bus between a host master and the region bridge.
interface avmm_region_bridge_if #(
    parameter int DW = 32
);
    logic [31:0]     master_address;
    logic            master_read;
    logic            master_write;
    logic [DW-1:0]   master_writedata;
    logic [DW/8-1:0] master_byteenable;
    logic            master_waitrequest;
    logic [DW-1:0]   master_readdata;
    logic            master_readdatavalid;

    modport slave (
        input  master_address,
        input  master_read,
        input  master_write,
        input  master_writedata,
        input  master_byteenable,
        output master_waitrequest,
        output master_readdata,
        output master_readdatavalid
    );

    modport master (
        output master_address,
        output master_read,
        output master_write,
        output master_writedata,
        output master_byteenable,
        input  master_waitrequest,
        input  master_readdata,
        input  master_readdatavalid
    );
endinterface

// File: rtl/avmm_region_bridge.sv
// Region-decoding bridge: one outstanding Avalon-MM request is decoded on
// address[31:16] into a one-hot target select, with a local scratch/status
// pair in region 0 and a read-wait timeout that answers with ERR_DATA.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready; a read or write is captured on the next edge
// ST_ISSUE   | captured request executed (local, target strobe or error)
// ST_RD_WAIT | target read pending; waiting for dvalid or the timeout
module avmm_region_bridge #(
    parameter int                          DW           = 32,
    parameter int                          NUM_REGIONS  = 2,
    parameter logic [NUM_REGIONS*16-1:0]   REGION_BASES = {16'h5001, 16'h5000},
    parameter logic [15:0]                 SCRATCH_ADDR = 16'h0030,
    parameter logic [15:0]                 STATUS_ADDR  = 16'h0034,
    parameter int                          TIMEOUT      = 255,
    parameter logic [31:0]                 ERR_DATA     = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avmm_region_bridge_if.slave    avm,
    output logic [NUM_REGIONS-1:0] tgt_sel,
    output logic [15:0]            tgt_addr,
    output logic                   tgt_wr_en,
    output logic                   tgt_rd_en,
    output logic [DW-1:0]          tgt_wr_data,
    output logic [DW/8-1:0]        tgt_byteen,
    input  logic [DW-1:0]          tgt_rd_data,
    input  logic                   tgt_rd_dvalid,
    output logic                   err_timeout
);
    localparam int            BEW         = DW / 8;
    localparam logic [DW-1:0] ERR_WORD    = DW'(ERR_DATA);
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RD_WAIT} state_t;

    state_t                 state, state_nxt;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [NUM_REGIONS-1:0] cap_sel;
    logic [15:0]            cap_addr;
    logic [DW-1:0]          cap_wdata;
    logic [BEW-1:0]         cap_be;
    logic                   cap_wr;
    logic [DW-1:0]          scratch;
    logic [15:0]            timeout_cnt;
    logic [15:0]            wait_cnt;
    logic                   is_scratch, is_status, is_mapped;
    logic                   cap_en, scratch_we, status_clr, tcnt_inc, wait_clr, wait_inc;

    // Region decode of the live request; descending scan lets the lowest index win.
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (avm.master_address[31:16] == REGION_BASES[16*i +: 16]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    assign is_mapped   = |cap_sel;
    assign is_scratch  = cap_sel[0] && (cap_addr == SCRATCH_ADDR);
    assign is_status   = cap_sel[0] && (cap_addr == STATUS_ADDR);
    assign tgt_sel     = (state == ST_ISSUE || state == ST_RD_WAIT) ? cap_sel : '0;
    assign tgt_addr    = (|tgt_sel) ? cap_addr : 16'h0000;
    assign tgt_wr_data = cap_wdata;
    assign tgt_byteen  = cap_be;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and output decode; a simultaneous read+write is captured as a write.
    always_comb begin
        state_nxt                = state;
        avm.master_waitrequest   = 1'b1;
        avm.master_readdata      = '0;
        avm.master_readdatavalid = 1'b0;
        tgt_wr_en                = 1'b0;
        tgt_rd_en                = 1'b0;
        err_timeout              = 1'b0;
        cap_en                   = 1'b0;
        scratch_we               = 1'b0;
        status_clr               = 1'b0;
        tcnt_inc                 = 1'b0;
        wait_clr                 = 1'b0;
        wait_inc                 = 1'b0;
        unique case (state)
            ST_IDLE: begin
                avm.master_waitrequest = 1'b0;
                if (avm.master_read || avm.master_write) begin
                    cap_en    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_IDLE;
                if (cap_wr) begin
                    if (is_scratch)     scratch_we = 1'b1;
                    else if (is_status) status_clr = 1'b1;
                    else if (is_mapped) tgt_wr_en  = 1'b1;
                end else if (is_scratch) begin
                    avm.master_readdatavalid = 1'b1;
                    avm.master_readdata      = scratch;
                end else if (is_status) begin
                    avm.master_readdatavalid = 1'b1;
                    avm.master_readdata      = DW'(timeout_cnt);
                end else if (is_mapped) begin
                    tgt_rd_en = 1'b1;
                    wait_clr  = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end else begin
                    avm.master_readdatavalid = 1'b1;
                    avm.master_readdata      = ERR_WORD;
                end
            end
            ST_RD_WAIT: begin
                if (tgt_rd_dvalid) begin
                    avm.master_readdatavalid = 1'b1;
                    avm.master_readdata      = tgt_rd_data;
                    state_nxt                = ST_IDLE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    avm.master_readdatavalid = 1'b1;
                    avm.master_readdata      = ERR_WORD;
                    err_timeout              = 1'b1;
                    tcnt_inc                 = 1'b1;
                    state_nxt                = ST_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; held until the next accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_sel   <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_wr    <= 1'b0;
        end else if (cap_en) begin
            cap_sel   <= hit_sel;
            cap_addr  <= avm.master_address[15:0];
            cap_wdata <= avm.master_writedata;
            cap_be    <= avm.master_byteenable;
            cap_wr    <= avm.master_write;
        end
    end

    // Local scratch register with per-byte write enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scratch <= '0;
        end else if (scratch_we) begin
            for (int b = 0; b < BEW; b++) begin
                if (cap_be[b]) scratch[8*b +: 8] <= cap_wdata[8*b +: 8];
            end
        end
    end

    // Saturating count of read timeouts; any status write clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)                                    timeout_cnt <= '0;
        else if (status_clr)                           timeout_cnt <= '0;
        else if (tcnt_inc && timeout_cnt != 16'hFFFF)  timeout_cnt <= timeout_cnt + 16'd1;
    end

    // Read-wait cycle counter, restarted when a target read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n)        wait_cnt <= '0;
        else if (wait_clr) wait_cnt <= '0;
        else if (wait_inc) wait_cnt <= wait_cnt + 16'd1;
    end
endmodule
